ring_slot_scheduler: RTL and testbench
======================================

Name: ring_slot_scheduler

Overview:
- Round-robin time-slot scheduler that shares one resource among NUM_SLOTS requesters.
- Uses a circulating one-hot token, the same rotation scheme as the team's 4-bit ring counter.
- Controls the token with Start/Stop commands and holds each grant for a programmable dwell time.
- Sits between requesting engines and the shared resource; software or a sequencer issues the commands.

Parameters:
- NUM_SLOTS, 4, number of requesters and token width (must be ≥2).
- INDEX_WIDTH, 2, width of Slot_Index_Out (must equal clog2(NUM_SLOTS)).
- DWELL_WIDTH, 8, width of the dwell-time input and its down-counter.

Ports:
- Clk_In  input  1  clock; all state updates on the falling edge.
- Reset_N_In  input  1  asynchronous, active-low reset.
- Enable_In  input  1  output enable; when 0, all outputs are Z and internal state keeps running.
- Start_Command_In  input  1  start scheduling.
- Stop_Command_In  input  1  stop scheduling.
- Dwell_Cycles_In  input  DWELL_WIDTH  grant length in cycles; sampled at grant entry.
- Request_In  input  NUM_SLOTS  per-slot request, level-sensitive.
- Grant_Out  output  NUM_SLOTS  one-hot grant; all zero when no slot is granted.
- Slot_Index_Out  output  INDEX_WIDTH  binary index of the current token position.
- Scheduler_Running_Flag_Out  output  1  high in SCAN and HOLD.
- Slot_Done_Pulse_Out  output  1  one-cycle pulse after each grant ends.

Behaviour:
- Reset (Reset_N_In=0, asynchronous) sets:
  - state=IDLE, token=...0001, Grant_Out=0, Slot_Index_Out=0
  - running=0, done pulse=0, dwell counter=0, stop_pending=0.
- States are IDLE, SCAN and HOLD; all outputs are registered.
- IDLE:
  - Grant_Out=0, running=0.
  - Start=1 moves to SCAN at the next edge. The token is retained from the last run; it is not reset.
  - Stop alone in IDLE has no effect.
- SCAN (one slot examined per edge):
  - If Request_In[token] is 1: move to HOLD, Grant_Out<=token, load counter with max(Dwell_Cycles_In,1)-1.
  - Otherwise rotate the token left by one ({token[N-2:0],token[N-1]}) and stay in SCAN.
  - Worst-case grant latency after a request is NUM_SLOTS edges.
  - Stop=1 moves to IDLE at the next edge (no grant issued) and the token is held.
- HOLD:
  - Grant_Out stays equal to the token, so the grant is visible for exactly max(D,1) cycles.
  - Release happens at the edge where counter==0 OR Request_In[token]==0 (early release). Otherwise the counter decrements.
  - On release: Grant_Out<=0, token rotates by one, Slot_Done_Pulse_Out<=1 for exactly one cycle.
  - After release, the next state is IDLE if stop_pending is set (clear stop_pending), else SCAN.
  - Stop=1 during HOLD sets stop_pending; the current grant is never truncated by Stop.
  - Dwell_Cycles_In changes during HOLD are ignored.
- Simultaneous events:
  - Start and Stop on the same edge: Start wins, matching the counter's command priority. In IDLE this means go to SCAN; in HOLD it clears stop_pending.
  - Start in SCAN/HOLD with no Stop: ignored.
  - A request arriving on the release edge is not seen by the slot being released; the token has already advanced.
- Token and index:
  - The token is always exactly one-hot and wraps from slot N-1 to slot 0.
  - Slot_Index_Out = binary(token) in every state.
- Running flag: 1 in SCAN/HOLD, 0 in IDLE. It drops at the same edge the state enters IDLE.
- Enable_In=0: outputs are Z; commands and requests are still sampled, and the FSM, counter and token still advance.
- Reset mid-HOLD: grant drops immediately (asynchronously) and no done pulse is generated.

Test Plan:
- Reset, then Start with Request_In=0001, Dwell=3: SCAN on edge 1, Grant=0001 for 3 cycles, done pulse, token=0010, Slot_Index=1.
- Request_In=1111, Dwell=2, free-running: grants 0001,0010,0100,1000,0001 in turn, each 2 cycles, with one SCAN cycle between them. No grant is ever multi-hot.
- Request_In=0100 only, token at 0001: grant asserts 3 edges after entering SCAN. Drop Request_In[2] after 1 grant cycle -> early release, done pulse, token=1000.
- Stop during HOLD with Dwell=5: grant completes all 5 cycles, then IDLE with running=0. A later Start resumes from the rotated token.
- Dwell=0 -> grant lasts 1 cycle. Start+Stop on the same edge in IDLE -> enters SCAN.
- Reset_N_In low mid-HOLD -> Grant_Out=0, token=0001 immediately. Enable_In=0 -> all outputs Z while the grant sequence continues internally.

Source files
------------

// File: rtl/ring_slot_scheduler.sv
// rtl/ring_slot_scheduler.sv - round-robin one-hot token slot scheduler with programmable dwell
module ring_slot_scheduler #(
    parameter int NUM_SLOTS   = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   Clk_In,
    input  logic                   Reset_N_In,
    input  logic                   Enable_In,
    input  logic                   Start_Command_In,
    input  logic                   Stop_Command_In,
    input  logic [DWELL_WIDTH-1:0] Dwell_Cycles_In,
    input  logic [NUM_SLOTS-1:0]   Request_In,
    output logic [NUM_SLOTS-1:0]   Grant_Out,
    output logic [INDEX_WIDTH-1:0] Slot_Index_Out,
    output logic                   Scheduler_Running_Flag_Out,
    output logic                   Slot_Done_Pulse_Out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_SLOTS-1:0]   token_q, token_d;
    logic [NUM_SLOTS-1:0]   grant_q, grant_d;
    logic [DWELL_WIDTH-1:0] count_q, count_d;
    logic                   done_q, done_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   running_q;
    logic [INDEX_WIDTH-1:0] index_q;

    logic [NUM_SLOTS-1:0]   token_rot;
    logic                   req_at_token;
    logic                   stop_eff;
    logic                   pend_now;
    logic [DWELL_WIDTH-1:0] dwell_load;

    function automatic logic [INDEX_WIDTH-1:0] to_index(input logic [NUM_SLOTS-1:0] oh);
        logic [INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (oh[i]) begin
                idx = idx | INDEX_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    assign token_rot    = {token_q[NUM_SLOTS-2:0], token_q[NUM_SLOTS-1]};
    assign req_at_token = |(Request_In & token_q);
    // Start outranks Stop whenever both arrive together.
    assign stop_eff     = Stop_Command_In & ~Start_Command_In;
    assign pend_now     = Start_Command_In ? 1'b0 : (stop_pend_q | Stop_Command_In);
    assign dwell_load   = (Dwell_Cycles_In == '0) ? '0 : Dwell_Cycles_In - DWELL_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        token_d     = token_q;
        grant_d     = grant_q;
        count_d     = count_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (Start_Command_In) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                grant_d = '0;
                if (stop_eff) begin
                    state_d = ST_IDLE;
                end else if (req_at_token) begin
                    state_d = ST_HOLD;
                    grant_d = token_q;
                    count_d = dwell_load;
                end else begin
                    token_d = token_rot;
                end
            end
            ST_HOLD: begin
                stop_pend_d = pend_now;
                // Stop never truncates a grant; it only decides where release goes.
                if ((count_q == '0) || !req_at_token) begin
                    grant_d     = '0;
                    token_d     = token_rot;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = pend_now ? ST_IDLE : ST_SCAN;
                end else begin
                    count_d = count_q - DWELL_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(negedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q     <= ST_IDLE;
            token_q     <= NUM_SLOTS'(1);
            grant_q     <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            running_q   <= 1'b0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            token_q     <= token_d;
            grant_q     <= grant_d;
            count_q     <= count_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            running_q   <= (state_d != ST_IDLE);
            index_q     <= to_index(token_d);
        end
    end

    assign Grant_Out                  = Enable_In ? grant_q   : 'z;
    assign Slot_Index_Out             = Enable_In ? index_q   : 'z;
    assign Scheduler_Running_Flag_Out = Enable_In ? running_q : 1'bz;
    assign Slot_Done_Pulse_Out        = Enable_In ? done_q    : 1'bz;

endmodule

// File: tb/tb_ring_slot_scheduler.sv
// tb/tb_ring_slot_scheduler.sv - scoreboard bench for ring_slot_scheduler
module tb_ring_slot_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       start_cmd;
    logic       stop_cmd;
    logic [7:0] dwell;
    logic [3:0] req;
    wire  [3:0] grant;
    wire  [1:0] slot_idx;
    wire        running;
    wire        done;

    ring_slot_scheduler #(
        .NUM_SLOTS  (4),
        .INDEX_WIDTH(2),
        .DWELL_WIDTH(8)
    ) dut (
        .Clk_In                    (clk),
        .Reset_N_In                (rst_n),
        .Enable_In                 (enable),
        .Start_Command_In          (start_cmd),
        .Stop_Command_In           (stop_cmd),
        .Dwell_Cycles_In           (dwell),
        .Request_In                (req),
        .Grant_Out                 (grant),
        .Slot_Index_Out            (slot_idx),
        .Scheduler_Running_Flag_Out(running),
        .Slot_Done_Pulse_Out       (done)
    );

    typedef struct {
        logic [3:0] grant;
        int         len;
        logic [1:0] idx_after;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A disabled output must not drive a value; 2-state simulators read released nets as 0.
    task automatic chk_off(input string name, input logic [3:0] v);
        n_cmp++;
        if (!(v === 4'bzzzz || v === 4'b0000)) begin
            n_bad++;
            $display("FAIL %s: got %b expected z", name, v);
        end
    endtask

    logic [3:0] prev_grant = 4'b0;
    int         run_len    = 0;
    logic       active     = 1'b0;
    exp_t       cur;

    always @(posedge clk) begin
        if (mon_en) begin
            if (grant !== 4'b0 && prev_grant === 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got %b expected none", grant);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_value", {28'b0, grant}, {28'b0, cur.grant});
                    run_len = 1;
                    active  = 1'b1;
                end
            end else if (grant !== 4'b0) begin
                run_len++;
            end
            if (grant !== 4'b0) begin
                chk("grant_onehot", $countones(grant), 1);
            end
            if (done === 1'b1 && active) begin
                chk("grant_length", run_len, cur.len);
                chk("index_after_release", {30'b0, slot_idx}, {30'b0, cur.idx_after});
                active = 1'b0;
            end
            prev_grant = grant;
        end else begin
            active     = 1'b0;
            prev_grant = 4'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
    endtask

    task automatic push(input logic [3:0] g, input int len, input logic [1:0] idx);
        exp_t e;
        e.grant     = g;
        e.len       = len;
        e.idx_after = idx;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start_cmd = 1'b0;
        stop_cmd  = 1'b0;
        req       = 4'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_cmd = 1'b1;
        tick();
        stop_cmd = 1'b0;
    endtask

    task automatic finish_test();
        req = 4'b0;
        pulse_stop();
        tick();
        chk("idle_after_stop", {31'b0, running}, 32'd0);
    endtask

    task automatic wait_done(input int max_cyc);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (done !== 1'b1 && k < max_cyc);
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: got timeout after %0d cycles expected done pulse", k);
        end
    endtask

    task automatic wait_grant(input int max_cyc, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (grant === 4'b0 && lat < max_cyc);
    endtask

    int lat;

    initial begin
        enable    = 1'b1;
        rst_n     = 1'b0;
        start_cmd = 1'b0;
        stop_cmd  = 1'b0;
        dwell     = 8'd0;
        req       = 4'b0;
        tick();
        chk("reset_grant",   {28'b0, grant},    32'd0);
        chk("reset_index",   {30'b0, slot_idx}, 32'd0);
        chk("reset_running", {31'b0, running},  32'd0);
        chk("reset_done",    {31'b0, done},     32'd0);

        // Single requester, dwell 3
        do_reset();
        req   = 4'b0001;
        dwell = 8'd3;
        push(4'b0001, 3, 2'd1);
        pulse_start();
        chk("running_in_scan", {31'b0, running}, 32'd1);
        chk("scan_index",      {30'b0, slot_idx}, 32'd0);
        wait_done(20);
        finish_test();

        // All requesting, dwell 2: full rotation plus wrap
        do_reset();
        req   = 4'b1111;
        dwell = 8'd2;
        push(4'b0001, 2, 2'd1);
        push(4'b0010, 2, 2'd2);
        push(4'b0100, 2, 2'd3);
        push(4'b1000, 2, 2'd0);
        push(4'b0001, 2, 2'd1);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            wait_done(20);
        end
        finish_test();

        // Lone request on slot 2, early release after one cycle
        do_reset();
        req   = 4'b0100;
        dwell = 8'd5;
        push(4'b0100, 1, 2'd3);
        pulse_start();
        wait_grant(20, lat);
        chk("scan_latency_slot2", lat, 3);
        req = 4'b0000;
        wait_done(20);
        finish_test();

        // Stop during HOLD completes the grant, then resume from rotated token
        do_reset();
        req   = 4'b0001;
        dwell = 8'd5;
        push(4'b0001, 5, 2'd1);
        pulse_start();
        wait_grant(20, lat);
        chk("grant_latency_slot0", lat, 1);
        pulse_stop();
        wait_done(20);
        chk("running_drops_on_release", {31'b0, running}, 32'd0);
        tick();
        req   = 4'b0010;
        dwell = 8'd1;
        push(4'b0010, 1, 2'd2);
        pulse_start();
        wait_grant(20, lat);
        chk("resume_latency", lat, 1);
        wait_done(20);
        finish_test();

        // Dwell 0 acts as 1; Start and Stop together in IDLE enter SCAN
        do_reset();
        req       = 4'b1000;
        dwell     = 8'd0;
        push(4'b1000, 1, 2'd0);
        start_cmd = 1'b1;
        stop_cmd  = 1'b1;
        tick();
        start_cmd = 1'b0;
        stop_cmd  = 1'b0;
        chk("start_wins_running", {31'b0, running}, 32'd1);
        wait_done(20);
        finish_test();

        // Asynchronous reset in the middle of HOLD
        do_reset();
        mon_en = 1'b0;
        req    = 4'b0001;
        dwell  = 8'd8;
        pulse_start();
        wait_grant(20, lat);
        chk("pre_reset_grant", {28'b0, grant}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_grant",   {28'b0, grant},    32'd0);
        chk("async_reset_index",   {30'b0, slot_idx}, 32'd0);
        chk("async_reset_running", {31'b0, running},  32'd0);
        chk("async_reset_done",    {31'b0, done},     32'd0);
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        dwell  = 8'd1;
        push(4'b0001, 1, 2'd1);
        pulse_start();
        wait_grant(20, lat);
        chk("token_reset_latency", lat, 1);
        wait_done(20);
        finish_test();

        // Outputs released while the schedule keeps advancing
        do_reset();
        mon_en = 1'b0;
        enable = 1'b0;
        req    = 4'b1111;
        dwell  = 8'd2;
        pulse_start();
        chk_off("off_grant_p1",   grant);
        chk_off("off_running_p1", {3'b0, running});
        repeat (5) tick();
        chk_off("off_grant_p6",   grant);
        chk_off("off_index_p6",   {2'b0, slot_idx});
        chk_off("off_running_p6", {3'b0, running});
        repeat (2) tick();
        enable = 1'b1;
        #1;
        chk("reenable_grant",   {28'b0, grant},    32'h4);
        chk("reenable_index",   {30'b0, slot_idx}, 32'd2);
        chk("reenable_running", {31'b0, running},  32'd1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
